// File: rtl/bus_pkg.sv
// Shared definitions for the single-outstanding bus initiator: FSM encoding,
// default timeout and the wait-counter width.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bus_state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;
  localparam int unsigned CNT_W                  = 16;

endpackage

// File: rtl/timeout_counter.sv
// Wait-cycle counter: cleared while idle, counts stalled bus cycles and flags
// when the count has reached the programmed limit.
import bus_pkg::*;

module timeout_counter (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count_reg;

  // Holds at the limit so the flag can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != limit)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == limit);

endmodule

// File: rtl/bus_initiator.sv
// Converts one command at a time into a valid/ready bus request, with a
// bounded wait for the responder and a held response until consumed.
import bus_pkg::*;

module bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  bus_state_t  state_reg;
  logic        cmd_ready_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;
  logic        mem_valid_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [3:0]  mem_wstrb_reg;
  logic        wait_expired;

  timeout_counter u_timeout_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_reg != BUS),
    .enable  ((state_reg == BUS) && !mem_ready),
    .limit   (TIMEOUT_LIMIT),
    .expired (wait_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cmd_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      mem_valid_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid && cmd_ready_reg) begin
            cmd_ready_reg <= 1'b0;
            if (cmd_write && (cmd_wstrb == 4'b0000)) begin
              // A write that enables no bytes is rejected without touching the bus.
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_rdata_reg <= '0;
              rsp_err_reg   <= 1'b1;
            end else begin
              state_reg     <= BUS;
              mem_valid_reg <= 1'b1;
              mem_addr_reg  <= cmd_addr;
              mem_wdata_reg <= cmd_wdata;
              mem_wstrb_reg <= cmd_write ? cmd_wstrb : 4'b0000;
            end
          end
        end
        BUS: begin
          if (mem_ready || wait_expired) begin
            state_reg     <= RESP;
            mem_valid_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
            rsp_valid_reg <= 1'b1;
            // Completion wins over a timeout landing on the same cycle.
            rsp_err_reg   <= !mem_ready;
            rsp_rdata_reg <= (mem_ready && (mem_wstrb_reg == 4'b0000)) ? mem_rdata : '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          cmd_ready_reg <= 1'b1;
          rsp_valid_reg <= 1'b0;
          mem_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign mem_valid = mem_valid_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator with a 4-cycle timeout: writes, reads,
// timeout, late completion, rejected write and reset abort.
module tb_bus_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  bus_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic offer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_rsp_valid_after_hs"}, 32'(rsp_valid), 32'd0);
    check({tag, "_cmd_ready_after_hs"}, 32'(cmd_ready), 32'd1);
    $display("txn %s done", tag);
  endtask

  initial begin
    int n_valid;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    reset = 1'b0;
    tick();

    // Write with mem_ready tied high: mem_valid at N+1, rsp_valid at N+2.
    mem_ready = 1'b1;
    offer(1'b1, 32'h1000_0000, 32'h0000_00A5, 4'b0001);
    check("wr_cmd_ready_N", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("wr_mem_valid_N1", 32'(mem_valid), 32'd1);
    check("wr_mem_addr", mem_addr, 32'h1000_0000);
    check("wr_mem_wdata", mem_wdata, 32'h0000_00A5);
    check("wr_mem_wstrb", 32'(mem_wstrb), 32'h1);
    check("wr_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    check("wr_rsp_valid_N1", 32'(rsp_valid), 32'd0);
    tick();
    check("wr_mem_valid_N2", 32'(mem_valid), 32'd0);
    check("wr_rsp_valid_N2", 32'(rsp_valid), 32'd1);
    check("wr_rsp_err", 32'(rsp_err), 32'd0);
    check("wr_cmd_ready_resp", 32'(cmd_ready), 32'd0);
    mem_ready = 1'b0;
    handshake("write");

    // Read with 3 wait cycles; strobes offered must be forced to zero.
    mem_rdata = 32'h0000_005A;
    offer(1'b0, 32'h1000_0004, 32'hFFFF_FFFF, 4'b1111);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rd_mem_valid_wait", 32'(mem_valid), 32'd1);
      check("rd_mem_wstrb_wait", 32'(mem_wstrb), 32'd0);
      check("rd_mem_addr_wait", mem_addr, 32'h1000_0004);
      check("rd_rsp_valid_wait", 32'(rsp_valid), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    check("rd_mem_valid_last", 32'(mem_valid), 32'd1);
    check("rd_mem_wstrb_last", 32'(mem_wstrb), 32'd0);
    tick();
    mem_ready = 1'b0;
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_rdata", rsp_rdata, 32'h0000_005A);
    check("rd_rsp_err", 32'(rsp_err), 32'd0);
    check("rd_mem_valid_resp", 32'(mem_valid), 32'd0);
    handshake("read");

    // Timeout: mem_ready never asserted, read data on the bus must not leak.
    mem_rdata = 32'hDEAD_BEEF;
    offer(1'b0, 32'h2000_0000, 32'h0, 4'b0000);
    n_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cmd_valid = 1'b0;
      if (mem_valid) n_valid++;
      if (rsp_valid) break;
    end
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_mem_valid_cycles", 32'(n_valid), 32'd4);
    check("to_rsp_err", 32'(rsp_err), 32'd1);
    check("to_rsp_rdata", rsp_rdata, 32'd0);
    handshake("timeout");

    // Completion on the 4th (timeout) cycle wins.
    offer(1'b1, 32'h3000_0008, 32'h1234_5678, 4'b1100);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_mem_valid", 32'(mem_valid), 32'd1);
      check("late_mem_wstrb", 32'(mem_wstrb), 32'hC);
      tick();
    end
    mem_ready = 1'b1;
    check("late_mem_valid_4th", 32'(mem_valid), 32'd1);
    tick();
    mem_ready = 1'b0;
    check("late_rsp_valid", 32'(rsp_valid), 32'd1);
    check("late_rsp_err", 32'(rsp_err), 32'd0);
    check("late_rsp_rdata", rsp_rdata, 32'd0);
    handshake("late_ready");

    // Write with no byte enables: rejected, bus untouched, response held.
    mem_ready = 1'b1;
    offer(1'b1, 32'h4000_0000, 32'hCAFE_F00D, 4'b0000);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("zs_mem_valid", 32'(mem_valid), 32'd0);
      check("zs_rsp_valid", 32'(rsp_valid), 32'd1);
      check("zs_rsp_err", 32'(rsp_err), 32'd1);
      check("zs_rsp_rdata", rsp_rdata, 32'd0);
      check("zs_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    mem_ready = 1'b0;
    handshake("zero_strobe");

    // Reset during BUS aborts without a response.
    offer(1'b0, 32'h5000_0000, 32'h0, 4'b0000);
    tick();
    cmd_valid = 1'b0;
    check("rb_mem_valid_bus", 32'(mem_valid), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("rb_mem_valid_abort", 32'(mem_valid), 32'd0);
    check("rb_rsp_valid_abort", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rb_rsp_valid_after", 32'(rsp_valid), 32'd0);
      check("rb_mem_valid_after", 32'(mem_valid), 32'd0);
      check("rb_cmd_ready_after", 32'(cmd_ready), 32'd1);
    end
    $display("txn reset_abort done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
